// File: rtl/udp_tx_framer.sv
// -----------------------------------------------------------------------------
// udp_tx_framer
//
// Reads one filled half of the 2 x 1024 x 16-bit ping-pong RAM and emits a
// single UDP datagram as a 16-bit word stream: a 4-word UDP header
// (src port, dst port, length in bytes, zero checksum) followed by the payload
// words. RAM reads are prefetched during the header into a 2-entry buffer, so
// the payload streams without bubbles while tx_ready is held high.
//
// Optional feature macro: UDP_SEQ_EN
//   When defined, a 16-bit frame sequence number is inserted as the first
//   payload word. The counter advances after every completed frame.
//
// Ports
//   clk, nRST      clock, asynchronous active-low reset
//   udp_start      frame request (rising edge used)
//   ping_pong      upstream write-bank select; frame reads bank ~ping_pong
//   length         payload length in words, 1..1024
//   ram_q          RAM read data, valid the cycle after ram_rden
//   ram_rd_addr    RAM read address {bank, index[9:0]}
//   ram_rden       RAM read enable
//   tx_data/tx_valid/tx_sop/tx_eop/tx_ready   output word stream
//   udp_busy       frame in progress
//   err_len        sticky: request with out-of-range length
//   err_ovr        sticky: request while busy
// -----------------------------------------------------------------------------
module udp_tx_framer #(
    parameter logic [15:0] SRC_PORT = 16'd5000,
    parameter logic [15:0] DST_PORT = 16'd5001
) (
    input  logic        clk,
    input  logic        nRST,
    input  logic        udp_start,
    input  logic        ping_pong,
    input  logic [15:0] length,
    input  logic [15:0] ram_q,
    output logic [10:0] ram_rd_addr,
    output logic        ram_rden,
    output logic [15:0] tx_data,
    output logic        tx_valid,
    output logic        tx_sop,
    output logic        tx_eop,
    input  logic        tx_ready,
    output logic        udp_busy,
    output logic        err_len,
    output logic        err_ovr
);

`ifdef UDP_SEQ_EN
    localparam logic [10:0] SEQ_WORDS = 11'd1;
    localparam logic [15:0] SEQ_BYTES = 16'd2;
`else
    localparam logic [10:0] SEQ_WORDS = 11'd0;
    localparam logic [15:0] SEQ_BYTES = 16'd0;
`endif

    typedef enum logic [1:0] {IDLE, HDR, PAY} state_t;

    state_t      state_reg, state_next;
    logic        start_prev_reg;
    logic [10:0] len_reg, len_next;
    logic        bank_reg, bank_next;
    logic [10:0] widx_reg, widx_next;      // index within frame of the word on tx_data
    logic [10:0] rd_idx_reg, rd_idx_next;  // next RAM index to read
    logic        rd_pend_reg;              // a read was issued last cycle: ram_q valid now
    logic [1:0]  buf_cnt_reg, buf_cnt_next;
    logic        buf_rd_ptr_reg, buf_wr_ptr_reg;
    logic [15:0] buf_q [2];
    logic [15:0] tx_data_reg, tx_data_next;
    logic        tx_valid_reg, tx_valid_next;
    logic        tx_sop_reg, tx_sop_next;
    logic        tx_eop_reg, tx_eop_next;
    logic        err_len_reg, err_len_next;
    logic        err_ovr_reg, err_ovr_next;
`ifdef UDP_SEQ_EN
    logic [15:0] seq_reg, seq_next;
`endif

    logic        start_edge, len_ok, busy, advance, finish;
    logic        seq_slot, buf_avail, pop, pop_buf, push, rd_issue;
    logic [10:0] next_idx, frame_last;
    logic [15:0] buf_head, udp_len_word;
    logic [2:0]  occ_after;

    assign start_edge   = udp_start & ~start_prev_reg;
    assign len_ok       = (length != 16'd0) && (length <= 16'd1024);
    assign busy         = (state_reg != IDLE);
    assign advance      = busy && (!tx_valid_reg || tx_ready);
    assign finish       = advance && tx_valid_reg && tx_eop_reg;
    assign next_idx     = widx_reg + 11'd1;
    assign frame_last   = len_reg + 11'd3 + SEQ_WORDS;
    assign udp_len_word = 16'd8 + {4'd0, len_reg, 1'b0} + SEQ_BYTES;
`ifdef UDP_SEQ_EN
    assign seq_slot     = (next_idx == 11'd4);
`else
    assign seq_slot     = 1'b0;
`endif

    // Payload source: buffered words first, otherwise the word arriving on
    // ram_q this cycle is forwarded straight to the output register.
    assign buf_avail = (buf_cnt_reg != 2'd0) || rd_pend_reg;
    assign buf_head  = (buf_cnt_reg != 2'd0) ? buf_q[buf_rd_ptr_reg] : ram_q;
    assign pop       = advance && !finish && (next_idx >= 11'd4) && !seq_slot && buf_avail;
    assign pop_buf   = pop && (buf_cnt_reg != 2'd0);
    assign push      = rd_pend_reg && !(pop && (buf_cnt_reg == 2'd0));

    // Words held after this edge; a new read is only issued if its data is
    // guaranteed a buffer slot even when nothing is consumed next cycle.
    assign occ_after = {1'b0, buf_cnt_reg} + {2'b00, rd_pend_reg} - {2'b00, pop};
    assign rd_issue  = busy && (rd_idx_reg < len_reg) && (occ_after <= 3'd1);

    always_comb begin
        state_next    = state_reg;
        len_next      = len_reg;
        bank_next     = bank_reg;
        widx_next     = widx_reg;
        rd_idx_next   = rd_idx_reg;
        tx_data_next  = tx_data_reg;
        tx_valid_next = tx_valid_reg;
        tx_sop_next   = tx_sop_reg;
        tx_eop_next   = tx_eop_reg;
        err_len_next  = err_len_reg;
        err_ovr_next  = err_ovr_reg;
        buf_cnt_next  = buf_cnt_reg + {1'b0, push} - {1'b0, pop_buf};
`ifdef UDP_SEQ_EN
        seq_next      = seq_reg;
`endif
        if (rd_issue) begin
            rd_idx_next = rd_idx_reg + 11'd1;
        end

        case (state_reg)
            IDLE: begin
                if (start_edge) begin
                    if (len_ok) begin
                        len_next      = length[10:0];
                        bank_next     = ~ping_pong;  // upstream toggles before starting
                        widx_next     = 11'd0;
                        rd_idx_next   = 11'd0;
                        tx_data_next  = SRC_PORT;
                        tx_valid_next = 1'b1;
                        tx_sop_next   = 1'b1;
                        tx_eop_next   = 1'b0;
                        state_next    = HDR;
                    end else begin
                        err_len_next = 1'b1;
                    end
                end
            end
            default: begin
                if (start_edge) begin
                    err_ovr_next = 1'b1;
                end
                if (finish) begin
                    tx_valid_next = 1'b0;
                    tx_sop_next   = 1'b0;
                    tx_eop_next   = 1'b0;
                    state_next    = IDLE;
`ifdef UDP_SEQ_EN
                    seq_next      = seq_reg + 16'd1;
`endif
                end else if (advance) begin
                    tx_sop_next = 1'b0;
                    if (next_idx < 11'd4) begin
                        tx_valid_next = 1'b1;
                        tx_eop_next   = 1'b0;
                        widx_next     = next_idx;
                        case (next_idx[1:0])
                            2'd1:    tx_data_next = DST_PORT;
                            2'd2:    tx_data_next = udp_len_word;
                            default: tx_data_next = 16'h0000;
                        endcase
                    end else if (seq_slot || buf_avail) begin
`ifdef UDP_SEQ_EN
                        tx_data_next  = seq_slot ? seq_reg : buf_head;
`else
                        tx_data_next  = buf_head;
`endif
                        tx_valid_next = 1'b1;
                        tx_eop_next   = (next_idx == frame_last);
                        widx_next     = next_idx;
                        state_next    = PAY;
                    end else begin
                        tx_valid_next = 1'b0;
                        tx_eop_next   = 1'b0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_reg      <= IDLE;
            start_prev_reg <= 1'b0;
            len_reg        <= 11'd0;
            bank_reg       <= 1'b0;
            widx_reg       <= 11'd0;
            rd_idx_reg     <= 11'd0;
            rd_pend_reg    <= 1'b0;
            buf_cnt_reg    <= 2'd0;
            buf_rd_ptr_reg <= 1'b0;
            buf_wr_ptr_reg <= 1'b0;
            tx_data_reg    <= 16'd0;
            tx_valid_reg   <= 1'b0;
            tx_sop_reg     <= 1'b0;
            tx_eop_reg     <= 1'b0;
            err_len_reg    <= 1'b0;
            err_ovr_reg    <= 1'b0;
`ifdef UDP_SEQ_EN
            seq_reg        <= 16'd0;
`endif
        end else begin
            state_reg      <= state_next;
            start_prev_reg <= udp_start;
            len_reg        <= len_next;
            bank_reg       <= bank_next;
            widx_reg       <= widx_next;
            rd_idx_reg     <= rd_idx_next;
            rd_pend_reg    <= rd_issue;
            buf_cnt_reg    <= buf_cnt_next;
            buf_rd_ptr_reg <= buf_rd_ptr_reg ^ pop_buf;
            buf_wr_ptr_reg <= buf_wr_ptr_reg ^ push;
            tx_data_reg    <= tx_data_next;
            tx_valid_reg   <= tx_valid_next;
            tx_sop_reg     <= tx_sop_next;
            tx_eop_reg     <= tx_eop_next;
            err_len_reg    <= err_len_next;
            err_ovr_reg    <= err_ovr_next;
`ifdef UDP_SEQ_EN
            seq_reg        <= seq_next;
`endif
        end
    end

    // Buffer storage carries no reset; occupancy is tracked by buf_cnt_reg.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_q[buf_wr_ptr_reg] <= ram_q;
        end
    end

    assign ram_rden    = rd_issue;
    assign ram_rd_addr = {bank_reg, rd_idx_reg[9:0]};
    assign tx_data     = tx_data_reg;
    assign tx_valid    = tx_valid_reg;
    assign tx_sop      = tx_sop_reg;
    assign tx_eop      = tx_eop_reg;
    assign udp_busy    = busy;
    assign err_len     = err_len_reg;
    assign err_ovr     = err_ovr_reg;

endmodule

// File: tb/tb_udp_tx_framer.sv
// -----------------------------------------------------------------------------
// tb_udp_tx_framer
//
// Directed-plus-random bench for udp_tx_framer. A behavioural RAM model serves
// reads; each frame's expected word list is built from the datagram format
// (header fields, optional sequence number, RAM contents of the selected
// bank) and compared word by word as the sink accepts them. Timing, handshake
// stability, read addresses, error flags and reset behaviour are also checked.
// -----------------------------------------------------------------------------
module tb_udp_tx_framer;

    logic        clk = 1'b0;
    logic        nRST;
    logic        udp_start;
    logic        ping_pong;
    logic [15:0] length;
    logic [15:0] ram_q;
    logic [10:0] ram_rd_addr;
    logic        ram_rden;
    logic [15:0] tx_data;
    logic        tx_valid;
    logic        tx_sop;
    logic        tx_eop;
    logic        tx_ready;
    logic        udp_busy;
    logic        err_len;
    logic        err_ovr;

`ifdef UDP_SEQ_EN
    localparam int SEQ = 1;
`else
    localparam int SEQ = 0;
`endif

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [15:0] mem [0:2047];
    logic [15:0] seq_model = 16'd0;

    udp_tx_framer dut (
        .clk         (clk),
        .nRST        (nRST),
        .udp_start   (udp_start),
        .ping_pong   (ping_pong),
        .length      (length),
        .ram_q       (ram_q),
        .ram_rd_addr (ram_rd_addr),
        .ram_rden    (ram_rden),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_sop      (tx_sop),
        .tx_eop      (tx_eop),
        .tx_ready    (tx_ready),
        .udp_busy    (udp_busy),
        .err_len     (err_len),
        .err_ovr     (err_ovr)
    );

    always #5 clk = ~clk;

    // RAM with registered read
    always @(posedge clk) begin
        if (ram_rden) ram_q <= mem[ram_rd_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"}, {25'd0, tx_valid, tx_sop, tx_eop, udp_busy, ram_rden, err_len, err_ovr}, 32'd0);
        chk({tag, "_dat"}, {5'd0, ram_rd_addr, tx_data}, 32'd0);
    endtask

    task automatic fill_bank(input int bk, input int n, input bit rnd);
        for (int i = 0; i < n; i++)
            mem[bk*1024 + i] = rnd ? 16'($urandom) : 16'(16'hA000 + i);
    endtask

    // One frame request. Entered and left on a falling clock edge.
    // bp: 0 ready always high, 1 pattern 1,0,0,1, 2 random
    // ovr: 0 none, 1 re-pulse udp_start mid-frame, 2 rising edge on eop accept
    // abort_at: payload word index at which nRST is asserted (-1: none)
    task automatic run_frame(input bit pp, input int n, input int bp, input int ovr, input int abort_at);
        logic [15:0] exp_q[$];
        int bk, f_len, cycles, zeros, widx, rd_exp, bubbles;
        bit done, stall_prev, r;
        logic [15:0] held_d;
        logic held_s, held_e;

        bk = pp ? 0 : 1;
        exp_q.push_back(16'd5000);
        exp_q.push_back(16'd5001);
        exp_q.push_back(16'(8 + 2 * (n + SEQ)));
        exp_q.push_back(16'h0000);
        if (SEQ != 0) exp_q.push_back(seq_model);
        for (int i = 0; i < n; i++) exp_q.push_back(mem[bk*1024 + i]);
        f_len = exp_q.size();

        ping_pong = pp; length = 16'(n); udp_start = 1'b1; tx_ready = 1'b1;
        @(negedge clk);
        udp_start = 1'b0;
        chk("start_busy", {31'd0, udp_busy}, 1);
        chk("start_valid", {31'd0, tx_valid}, 1);
        chk("start_sop", {31'd0, tx_sop}, 1);

        cycles = 0; zeros = 0; widx = 0; rd_exp = 0; bubbles = 0;
        done = 0; stall_prev = 0; held_d = 0; held_s = 0; held_e = 0;
        while (!done && cycles < 5000) begin
            cycles++;
            if (abort_at >= 0 && tx_valid && widx == 4 + SEQ + abort_at) begin
                nRST = 1'b0;
                #1;
                chk_all_zero("abort");
                @(negedge clk);
                nRST = 1'b1; tx_ready = 1'b1;
                seq_model = 16'd0;
                $display("frame aborted: bank=%0d n=%0d at payload word %0d", bk, n, abort_at);
                return;
            end
            case (bp)
                0:       r = 1'b1;
                1:       r = ((cycles - 1) % 4 == 0) || ((cycles - 1) % 4 == 3);
                default: r = 1'($urandom_range(0, 1));
            endcase
            if (ovr == 1 && cycles == 3) udp_start = 1'b1;
            if (ovr == 1 && cycles == 5) udp_start = 1'b0;
            if (ovr == 2 && tx_valid && tx_eop && r) udp_start = 1'b1;
            if (!tx_valid) bubbles++;
            if (stall_prev) begin
                chk("stall_valid", {31'd0, tx_valid}, 1);
                chk("stall_data", {16'd0, tx_data}, {16'd0, held_d});
                chk("stall_flags", {30'd0, tx_sop, tx_eop}, {30'd0, held_s, held_e});
            end
            tx_ready = r;
            #1;
            if (ram_rden) begin
                chk("rd_in_range", {31'd0, rd_exp < n}, 1);
                chk("rd_addr", {21'd0, ram_rd_addr}, 32'(bk*1024 + rd_exp));
                rd_exp++;
            end
            if (tx_valid && r) begin
                chk("word_in_frame", {31'd0, widx < f_len}, 1);
                if (widx < f_len) chk("word", {16'd0, tx_data}, {16'd0, exp_q[widx]});
                chk("sop", {31'd0, tx_sop}, {31'd0, widx == 0});
                chk("eop", {31'd0, tx_eop}, {31'd0, widx == f_len - 1});
                if (tx_eop) done = 1;
                widx++;
            end
            stall_prev = tx_valid && !r;
            held_d = tx_data; held_s = tx_sop; held_e = tx_eop;
            if (!r) zeros++;
            @(negedge clk);
        end
        chk("frame_done", {31'd0, done}, 1);
        chk("frame_words", 32'(widx), 32'(f_len));
        chk("frame_cycles", 32'(cycles), 32'(f_len + zeros));
        chk("no_bubbles", 32'(bubbles), 0);
        chk("reads_total", 32'(rd_exp), 32'(n));
        chk("end_busy", {30'd0, udp_busy, tx_valid}, 0);
        if (ovr != 0) chk("err_ovr_set", {31'd0, err_ovr}, 1);
        if (ovr == 2) begin
            udp_start = 1'b0;
            @(negedge clk);
            chk("ovr_no_restart", {30'd0, udp_busy, tx_valid}, 0);
        end
        if (done) seq_model = seq_model + 16'd1;
        tx_ready = 1'b1;
        $display("frame: bank=%0d n=%0d bp=%0d words=%0d cycles=%0d stalls=%0d seq_next=%0d",
                 bk, n, bp, widx, cycles, zeros, seq_model);
    endtask

    initial begin
        int n;
        bit pp;
        nRST = 1'b0; udp_start = 1'b0; ping_pong = 1'b0; length = 16'd0; tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk_all_zero("in_reset");
        nRST = 1'b1;
        @(negedge clk);
        chk_all_zero("after_reset");

        // Basic frame: bank 0 = A000..A003
        fill_bank(0, 4, 0);
        run_frame(1'b1, 4, 0, 0, -1);

        // Max length in bank 1
        fill_bank(1, 1024, 1);
        run_frame(1'b0, 1024, 0, 0, -1);

        // Back-pressure 1,0,0,1
        fill_bank(0, 8, 1);
        run_frame(1'b1, 8, 1, 0, -1);

        // Random lengths, banks and ready
        for (int f = 0; f < 4; f++) begin
            n  = $urandom_range(1, 40);
            pp = 1'($urandom_range(0, 1));
            fill_bank(pp ? 0 : 1, n, 1);
            run_frame(pp, n, 2, 0, -1);
        end

        // Length errors
        chk("err_len_clear", {31'd0, err_len}, 0);
        length = 16'd0; udp_start = 1'b1;
        @(negedge clk);
        chk("err_len_zero", {31'd0, err_len}, 1);
        chk("len0_no_frame", {30'd0, udp_busy, tx_valid}, 0);
        udp_start = 1'b0;
        @(negedge clk);
        length = 16'd1025; udp_start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            udp_start = 1'b0;
            chk("len1025_no_frame", {30'd0, udp_busy, tx_valid}, 0);
        end
        chk("err_ovr_clear", {31'd0, err_ovr}, 0);

        // Mid-frame re-pulse
        fill_bank(1, 8, 1);
        run_frame(1'b0, 8, 0, 1, -1);

        // Reset mid-frame, then a clean frame
        fill_bank(0, 8, 1);
        run_frame(1'b1, 8, 0, 0, 3);
        chk("errs_cleared", {30'd0, err_len, err_ovr}, 0);
        run_frame(1'b1, 8, 2, 0, -1);

        // Rising edge in the cycle the eop word is accepted
        chk("err_ovr_pre", {31'd0, err_ovr}, 0);
        fill_bank(1, 5, 1);
        run_frame(1'b0, 5, 0, 2, -1);

        // Three short frames after reset: sequence numbers 0,1,2 when enabled
        nRST = 1'b0;
        @(negedge clk);
        nRST = 1'b1; seq_model = 16'd0;
        @(negedge clk);
        for (int f = 0; f < 3; f++) begin
            fill_bank(f % 2, 2, 1);
            run_frame(1'((f + 1) % 2), 2, 0, 0, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/udp_tx_framer.md
# udp_tx_framer

Downstream consumer of the UDP pre-processing stage. Once the pre-processing stage has filled one half of the 2 × 1024 × 16-bit ping-pong RAM and pulsed `udp_start`, this block reads that half and emits one UDP datagram as a 16-bit word stream to the MAC/IP packer. The datagram is a 4-word UDP header followed by `length` payload words. `udp_busy` feeds back to the pre-processing stage to throttle it.

## Interface
- `SRC_PORT`, 16'd5000, UDP source port
- `DST_PORT`, 16'd5001, UDP destination port
- `clk`  in  1  system clock
- `nRST`  in  1  reset, asynchronous, active-low
- `udp_start`  in  1  frame request; level held ≥1 cycle; only its rising edge is used
- `ping_pong`  in  1  current write-bank select from the upstream stage
- `length`  in  16  payload length in 16-bit words; valid range 1..1024
- `ram_q`  in  16  RAM read data; valid the cycle after `ram_rden`
- `ram_rd_addr`  out  11  RAM read address {bank, index[9:0]}
- `ram_rden`  out  1  RAM read enable
- `tx_data`  out  16  stream word
- `tx_valid`  out  1  `tx_data` valid
- `tx_sop`  out  1  first word of frame (qualified by `tx_valid`)
- `tx_eop`  out  1  last word of frame (qualified by `tx_valid`)
- `tx_ready`  in  1  sink accepts word when `tx_valid && tx_ready`
- `udp_busy`  out  1  frame in progress
- `err_len`  out  1  sticky: request with `length` of 0 or >1024
- `err_ovr`  out  1  sticky: `udp_start` rising edge while busy

## Operation
- Reset values: all outputs 0. The previous-`udp_start` register resets to 0. Sequence counter resets to 0. State resets to IDLE.
- States: IDLE → HDR → PAY → IDLE.
- IDLE:
  - On a rising edge of `udp_start` with `length` in 1..1024: latch `length` and `bank = ~ping_pong`, because upstream toggles `ping_pong` before starting. Set `udp_busy`, then go to HDR.
  - If `length` is out of range: set `err_len`, stay in IDLE, emit nothing.
- HDR: emit 4 words in order:
  - `SRC_PORT`
  - `DST_PORT`
  - UDP length in bytes = 8 + 2·N, 16-bit
  - checksum 16'h0000
  - The first word carries `tx_sop`=1.
- PAY: emit N words read from addresses {bank, 0} .. {bank, N−1} in increasing order. The last word carries `tx_eop`=1.
  - Indices are 10 bits. N=1024 ends at index 1023 with no wrap into the other bank.
- Handshake:
  - `tx_data`, `tx_sop` and `tx_eop` hold stable while `tx_valid && !tx_ready`.
  - `tx_valid` never drops mid-frame unless the RAM read pipeline is empty. With `tx_ready` held at 1, the pipeline is never empty.
  - The block prefetches RAM reads during HDR and buffers up to 2 words, so there are no payload bubbles.
  - `ram_rden` must never issue a read whose data cannot be buffered.
- After the `tx_eop` word is accepted: clear `udp_busy`, go to IDLE.
- A `udp_start` rising edge while busy is ignored and sets `err_ovr`.
- Simultaneous case: a rising edge in the cycle the `eop` word is accepted counts as busy and sets `err_ovr`.
- Reset mid-frame aborts immediately with no `tx_eop`. The sink must discard a partial frame.

## Timing
- Edge sampled at rising clock T (`udp_start`=1, previous=0): `udp_busy`=1 and `tx_valid`=1 with word 0 from T+1.
- First `ram_rden` at T+1 or later, early enough to meet the no-bubble rule.
- With `tx_ready`=1 throughout: frame occupies exactly 4+N consecutive cycles, T+1 .. T+4+N. `udp_busy` falls at T+5+N.
- Back-pressure adds exactly one cycle per cycle of `tx_ready`=0. Word order and values are unchanged.
- `udp_busy` can be deasserted and reasserted with one idle cycle minimum between frames.
- `err_len` and `err_ovr` assert one cycle after the offending edge. They clear only on reset.

## Configuration
- `UDP_SEQ_EN` defined:
  - Insert a 16-bit frame sequence number as the first payload word, ahead of the N RAM words.
  - The UDP length field becomes 8 + 2·(N+1).
  - Frame length becomes 5+N words.
  - The counter increments after each completed frame and wraps 16'hFFFF → 0. It is not incremented on an aborted or rejected request.
- Undefined: no sequence word and no counter logic, exactly as described above.

## Test plan
- Basic frame: `ping_pong`=1, N=4, bank-0 RAM = 16'hA000..A003, `tx_ready`=1 → words 5000, 5001, 16, 0, A000..A003 on 8 consecutive cycles. `sop` on word 0, `eop` on A003. `ram_rd_addr` 0..3.
- Max length and bank 1: `ping_pong`=0, N=1024 → reads 11'h400..11'h7FF, UDP length 2056, 1028 cycles, no bubbles.
- Back-pressure: N=8, `tx_ready` toggling 1,0,0,1 … → data stable during stalls, identical word sequence, no loss or duplication.
- Errors: `length`=0, then `length`=1025 → no `tx_valid`, `err_len`=1. `udp_start` re-pulsed mid-frame → `err_ovr`=1, current frame unaffected.
- Reset mid-frame: deassert `nRST` at payload word 3 → all outputs 0 immediately. A new request after release produces a complete correct frame.
- With `UDP_SEQ_EN`: 3 frames with N=2 → sequence words 0, 1, 2, UDP length 14, 7-word frames.
